// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Definitions shared by the sequential Y86-64 core's control and datapath:
//   - instruction codes (icode field of the first instruction byte)
//   - processor status encodings reported on the stat output
//   - state encoding of the multi-cycle stage sequencer
// ---------------------------------------------------------------------------
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'd0,
                         I_NOP    = 4'd1,
                         I_RRMOVQ = 4'd2,
                         I_IRMOVQ = 4'd3,
                         I_RMMOVQ = 4'd4,
                         I_MRMOVQ = 4'd5,
                         I_OPQ    = 4'd6,
                         I_JXX    = 4'd7,
                         I_CALL   = 4'd8,
                         I_RET    = 4'd9,
                         I_PUSHQ  = 4'd10,
                         I_POPQ   = 4'd11;

  // Processor status
  localparam logic [2:0] STAT_AOK = 3'd1,
                         STAT_HLT = 3'd2,
                         STAT_ADR = 3'd3,
                         STAT_INS = 3'd4;

  // Sequencer states. One instruction walks FETCH..PCUPD, one clock each.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMORY  = 3'd4,
    S_WB      = 3'd5,
    S_PCUPD   = 3'd6,
    S_HALT    = 3'd7
  } seq_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC selection for the Y86-64 instruction set. Kept as a
// standalone block so a pipelined PC-prediction unit can share it.
//
// Ports:
//   icode_i   instruction code of the completing instruction
//   cnd_i     branch condition outcome (only meaningful for jXX)
//   valc_i    constant word (branch / call target)
//   valp_i    fall-through address
//   valm_i    word read from memory (return address for ret)
//   new_pc_o  selected next PC
// ---------------------------------------------------------------------------
module next_pc_sel
  import y86_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [3:0]      icode_i,
  input  logic            cnd_i,
  input  logic [PC_W-1:0] valc_i,
  input  logic [PC_W-1:0] valp_i,
  input  logic [PC_W-1:0] valm_i,
  output logic [PC_W-1:0] new_pc_o
);

  always_comb begin
    new_pc_o = valp_i;
    case (icode_i)
      I_CALL:  new_pc_o = valc_i;
      I_JXX:   new_pc_o = cnd_i ? valc_i : valp_i;
      I_RET:   new_pc_o = valm_i;
      default: new_pc_o = valp_i;
    endcase
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// ---------------------------------------------------------------------------
// seq_stage_ctrl
// Multi-cycle sequencer of the sequential Y86-64 core. Owns the architectural
// PC, pulses the five stage enables in order (one clock each, followed by a
// PC-update clock), selects the next PC and tracks processor status.
//
// Build option:
//   SEQ_SINGLE_STEP_EN  when defined, adds the 'step' input; each step pulse
//                       in IDLE runs exactly one instruction and the sequencer
//                       returns to IDLE afterwards ('run' is ignored).
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   step         (SEQ_SINGLE_STEP_EN only) single-instruction start pulse
//   run          level; keep issuing instructions while high
//   icode        instruction code from fetch, valid in DECODE
//   instr_valid  fetch's instruction-valid flag, valid with icode
//   cnd          condition flag from execute, valid in MEMORY
//   valC         constant word from fetch
//   valP         fall-through PC from fetch
//   valM         memory read data, valid in WB
//   dmem_err     data-memory address error, sampled in MEMORY
//   pc           architectural PC, read by fetch
//   fetch_en .. wb_en  one-cycle stage enable pulses
//   stat         1=AOK 2=HLT 3=ADR 4=INS
//   halted       high while halted
//   cycle_cnt    clocks spent outside IDLE/HALT (wraps)
//   instr_cnt    instructions retired through PCUPD (wraps)
// ---------------------------------------------------------------------------
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int              PC_W       = 64,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     IMEM_BYTES = 1024,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             run,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             cnd,
  input  logic [PC_W-1:0]  valC,
  input  logic [PC_W-1:0]  valP,
  input  logic [PC_W-1:0]  valM,
  input  logic             dmem_err,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             wb_en,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  seq_state_e       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [2:0]       stat_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;

  // Operands captured in the stage where they are valid, so that the
  // upstream units are free to change them afterwards.
  logic [3:0]       icode_q;
  logic             cnd_q;
  logic [PC_W-1:0]  valm_q;

  // Start / continue decisions differ between free-running and single-step
  // builds; everything else in the sequencer is shared.
  logic start_instr;
  logic continue_run;

`ifdef SEQ_SINGLE_STEP_EN
  logic unused_run;
  assign unused_run   = run;
  assign start_instr  = step;
  assign continue_run = 1'b0;
`else
  assign start_instr  = run;
  assign continue_run = run;
`endif

  // The last byte of a maximal (10-byte) instruction must lie inside
  // instruction memory. One extra bit keeps pc+10 from wrapping.
  logic [PC_W:0] pc_end;
  logic          addr_fault;

  assign pc_end     = {1'b0, pc_q} + (PC_W+1)'(10);
  assign addr_fault = pc_end > (PC_W+1)'(IMEM_BYTES);

  next_pc_sel #(
    .PC_W (PC_W)
  ) u_next_pc_sel (
    .icode_i  (icode_q),
    .cnd_i    (cnd_q),
    .valc_i   (valC),
    .valp_i   (valP),
    .valm_i   (valm_q),
    .new_pc_o (pc_d)
  );

  // Operand capture: plain data, no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) icode_q <= icode;
    if (state_q == S_MEMORY) cnd_q   <= cnd;
    if (state_q == S_WB)     valm_q  <= valM;
  end

  // Sequencer, status, PC and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      stat_q      <= STAT_AOK;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (start_instr) state_q <= S_FETCH;
        end

        S_FETCH: begin
          if (addr_fault) begin
            stat_q  <= STAT_ADR;
            state_q <= S_HALT;
          end else begin
            state_q <= S_DECODE;
          end
        end

        // An invalid instruction outranks a halt opcode.
        S_DECODE: begin
          if (!instr_valid) begin
            stat_q  <= STAT_INS;
            state_q <= S_HALT;
          end else if (icode == I_HALT) begin
            stat_q  <= STAT_HLT;
            state_q <= S_HALT;
          end else begin
            state_q <= S_EXECUTE;
          end
        end

        S_EXECUTE: state_q <= S_MEMORY;

        // A data fault stops before writeback; pc keeps the faulting address.
        S_MEMORY: begin
          if (dmem_err) begin
            stat_q  <= STAT_ADR;
            state_q <= S_HALT;
          end else begin
            state_q <= S_WB;
          end
        end

        S_WB: state_q <= S_PCUPD;

        S_PCUPD: begin
          pc_q        <= pc_d;
          instr_cnt_q <= instr_cnt_q + CNT_W'(1);
          state_q     <= continue_run ? S_FETCH : S_IDLE;
        end

        // Terminal until reset.
        S_HALT: state_q <= S_HALT;
      endcase
    end
  end

  // Enables decode straight from the registered state: one clock per pulse.
  assign fetch_en   = (state_q == S_FETCH);
  assign decode_en  = (state_q == S_DECODE);
  assign execute_en = (state_q == S_EXECUTE);
  assign memory_en  = (state_q == S_MEMORY);
  assign wb_en      = (state_q == S_WB);
  assign halted     = (state_q == S_HALT);

  assign pc        = pc_q;
  assign stat      = stat_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
module tb_seq_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic        run;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        cnd;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] valM;
  logic        dmem_err;
  logic [63:0] pc;
  logic        fetch_en, decode_en, execute_en, memory_en, wb_en;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seq_stage_ctrl dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .run         (run),
    .icode       (icode),
    .instr_valid (instr_valid),
    .cnd         (cnd),
    .valC        (valC),
    .valP        (valP),
    .valM        (valM),
    .dmem_err    (dmem_err),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .execute_en  (execute_en),
    .memory_en   (memory_en),
    .wb_en       (wb_en),
    .stat        (stat),
    .halted      (halted),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Enables packed as {fetch, decode, execute, memory, wb}.
  task automatic chk_en(input string tag, input logic [4:0] exp);
    chk(tag, {59'd0, fetch_en, decode_en, execute_en, memory_en, wb_en}, {59'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; icode = 4'd0; instr_valid = 1'b1; cnd = 1'b0;
    valC = '0; valP = '0; valM = '0; dmem_err = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(2);
    chk("rst_pc", pc, 64'd0);
    chk("rst_stat", {61'd0, stat}, 64'd1);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk_en("rst_en", 5'b00000);
    chk("rst_cycle", {32'd0, cycle_cnt}, 64'd0);
    chk("rst_instr", {32'd0, instr_cnt}, 64'd0);
    rst = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
    // run is ignored; only step pulses start an instruction.
    icode = 4'd3; valP = 64'h10; run = 1'b1;
    tick(2);
    chk_en("ss_idle_run", 5'b00000);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk_en("ss_fetch", 5'b10000);
      tick(6);
      chk_en("ss_back_idle", 5'b00000);
      chk("ss_instr_cnt", {32'd0, instr_cnt}, 64'(i + 1));
      tick(2);
      chk_en("ss_stay_idle", 5'b00000);
    end
    chk("ss_pc", pc, 64'h10);
`else
    // irmovq stream: fetch_en at cycles 1, 7, 13.
    icode = 4'd3; valP = 64'd10; run = 1'b1;
    tick(1);
    chk_en("c1_fetch", 5'b10000);
    tick(1); chk_en("c2_decode", 5'b01000);
    tick(1); chk_en("c3_execute", 5'b00100);
    tick(1); chk_en("c4_memory", 5'b00010);
    tick(1); chk_en("c5_wb", 5'b00001);
    tick(1); chk_en("c6_pcupd", 5'b00000);
    chk("c6_pc_not_yet", pc, 64'd0);
    tick(1);
    chk_en("c7_fetch", 5'b10000);
    chk("c7_pc", pc, 64'd10);
    chk("c7_instr", {32'd0, instr_cnt}, 64'd1);
    chk("c7_cycle", {32'd0, cycle_cnt}, 64'd6);
    tick(6);
    chk_en("c13_fetch", 5'b10000);
    chk("c13_instr", {32'd0, instr_cnt}, 64'd2);
    chk("c13_cycle", {32'd0, cycle_cnt}, 64'd12);

    // jXX taken
    icode = 4'd7; valC = 64'h40; valP = 64'd9; cnd = 1'b1;
    tick(6);
    chk("jxx_taken_pc", pc, 64'h40);
    chk("jxx_taken_instr", {32'd0, instr_cnt}, 64'd3);

    // jXX not taken; cnd rises after MEMORY and must be ignored
    cnd = 1'b0;
    tick(4);
    cnd = 1'b1;
    tick(2);
    chk("jxx_nt_pc", pc, 64'd9);

    // call; icode changes after DECODE and must be ignored
    icode = 4'd8; valC = 64'h100; valP = 64'd19;
    tick(2);
    icode = 4'd3;
    tick(4);
    chk("call_pc", pc, 64'h100);
    chk("call_instr", {32'd0, instr_cnt}, 64'd5);

    // ret
    icode = 4'd9; valM = 64'h0A; valP = 64'h102;
    tick(6);
    chk("ret_pc", pc, 64'h0A);

    // run drops mid-instruction: finish through PCUPD, then IDLE
    icode = 4'd3; valP = 64'h20;
    tick(1);
    run = 1'b0;
    tick(5);
    chk_en("rundrop_idle", 5'b00000);
    chk("rundrop_pc", pc, 64'h20);
    chk("rundrop_instr", {32'd0, instr_cnt}, 64'd7);
    chk("rundrop_cycle", {32'd0, cycle_cnt}, 64'd42);
    tick(2);
    chk("idle_cycle_hold", {32'd0, cycle_cnt}, 64'd42);
    chk_en("idle_en", 5'b00000);

    // invalid + halt opcode together: INS wins, no execute
    run = 1'b1; icode = 4'd0; instr_valid = 1'b0;
    tick(2);
    chk_en("ins_decode", 5'b01000);
    tick(1);
    chk("ins_stat", {61'd0, stat}, 64'd4);
    chk("ins_halted", {63'd0, halted}, 64'd1);
    chk_en("ins_no_execute", 5'b00000);
    run = 1'b0; tick(2);
    run = 1'b1; tick(2);
    chk("ins_pc_hold", pc, 64'h20);
    chk("ins_stat_hold", {61'd0, stat}, 64'd4);
    chk_en("ins_en_hold", 5'b00000);
    chk("ins_cycle_hold", {32'd0, cycle_cnt}, 64'd44);
    chk("ins_instr_hold", {32'd0, instr_cnt}, 64'd7);

    // reset out of HALT, then fetch-address fault at pc=1015
    rst = 1'b1; run = 1'b0; instr_valid = 1'b1; icode = 4'd3; valP = 64'd1015;
    tick(1);
    rst = 1'b0;
    chk("rst2_pc", pc, 64'd0);
    chk("rst2_stat", {61'd0, stat}, 64'd1);
    chk("rst2_halted", {63'd0, halted}, 64'd0);
    run = 1'b1;
    tick(7);
    chk_en("adr_fetch", 5'b10000);
    chk("adr_pc_pre", pc, 64'd1015);
    tick(1);
    chk("adr_stat", {61'd0, stat}, 64'd3);
    chk("adr_halted", {63'd0, halted}, 64'd1);
    chk("adr_pc", pc, 64'd1015);
    chk_en("adr_no_decode", 5'b00000);
    chk("adr_cycle", {32'd0, cycle_cnt}, 64'd7);

    // pc=1014 is the last legal fetch address; then a data fault
    rst = 1'b1; valP = 64'd1014;
    tick(1);
    rst = 1'b0;
    tick(7);
    chk("edge_pc", pc, 64'd1014);
    tick(1);
    chk_en("edge_decode", 5'b01000);
    chk("edge_stat", {61'd0, stat}, 64'd1);
    dmem_err = 1'b1;
    tick(2);
    chk_en("derr_memory", 5'b00010);
    tick(1);
    chk("derr_stat", {61'd0, stat}, 64'd3);
    chk("derr_halted", {63'd0, halted}, 64'd1);
    chk_en("derr_no_wb", 5'b00000);
    tick(3);
    chk_en("derr_no_wb_later", 5'b00000);
    chk("derr_pc", pc, 64'd1014);
    dmem_err = 1'b0;

    // reset arriving in WB discards the instruction
    rst = 1'b1; valP = 64'h30;
    tick(1);
    rst = 1'b0;
    tick(5);
    chk_en("wbrst_wb", 5'b00001);
    chk("wbrst_cycle_pre", {32'd0, cycle_cnt}, 64'd4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; run = 1'b0;
    chk("wbrst_pc", pc, 64'd0);
    chk("wbrst_stat", {61'd0, stat}, 64'd1);
    chk("wbrst_cycle", {32'd0, cycle_cnt}, 64'd0);
    chk("wbrst_instr", {32'd0, instr_cnt}, 64'd0);
    chk_en("wbrst_en", 5'b00000);
    tick(1);
    chk_en("wbrst_idle", 5'b00000);
    chk("wbrst_pc_idle", pc, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
Multi-cycle sequencer for the sequential Y86-64 core. It owns the architectural PC and issues one-cycle stage-enable pulses to fetch, decode, execute, memory and writeback, in that order. It selects the next PC from the instruction results and tracks processor status (AOK/HLT/ADR/INS). It sits above the fetch unit and the other stage units, and drives the PC that fetch reads.

Parameters:
PC_W, 64, width of PC, valC, valP, valM
RESET_PC, 0, PC value loaded on reset
IMEM_BYTES, 1024, instruction memory size in bytes; any PC+10 > IMEM_BYTES is an address fault
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
run  in  1  level; while 1, the controller keeps issuing instructions
icode  in  4  from fetch; valid in the DECODE-state cycle
instr_valid  in  1  from fetch; valid with icode
cnd  in  1  condition flag from execute; valid in MEMORY state
valC  in  PC_W  constant word from fetch
valP  in  PC_W  fall-through PC from fetch
valM  in  PC_W  memory read data; valid in WRITEBACK state
dmem_err  in  1  data-memory address error; sampled in MEMORY state
pc  out  PC_W  architectural PC, fed to fetch
fetch_en  out  1  one-cycle stage pulse
decode_en  out  1  one-cycle stage pulse
execute_en  out  1  one-cycle stage pulse
memory_en  out  1  one-cycle stage pulse
wb_en  out  1  one-cycle stage pulse
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
halted  out  1  high while in HALT state
cycle_cnt  out  CNT_W  clocks spent outside IDLE/HALT
instr_cnt  out  CNT_W  instructions retired (completed PCUPD)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous, active-high.
- Reset values: pc=RESET_PC, state=IDLE, all *_en=0, stat=AOK, halted=0, counters=0.
- Reset asserted in any state, including mid-instruction or HALT, has the same effect. The partially issued instruction is discarded.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WB, PCUPD, HALT.
- IDLE -> FETCH when run=1; otherwise stay in IDLE.
- FETCH -> DECODE -> EXECUTE -> MEMORY -> WB -> PCUPD, one clock each.
- PCUPD -> FETCH if run=1, else -> IDLE.
- Stage enables: fetch_en=1 only in FETCH, decode_en only in DECODE, execute_en only in EXECUTE, memory_en only in MEMORY, wb_en only in WB. Enables are decoded from the registered state, so each pulse lasts exactly one cycle.
- Latency: 6 clocks per instruction. The first fetch_en comes 1 clock after run is sampled high in IDLE.
- Address check in FETCH: if pc+10 > IMEM_BYTES (compare in PC_W+1 bits, no wrap), set stat=ADR and go to HALT. fetch_en stays asserted for that cycle.
- Decode checks in DECODE:
  - instr_valid=0 -> stat=INS, go to HALT.
  - icode=0 (halt) -> stat=HLT, go to HALT.
  - INS takes priority over HLT.
- Memory check in MEMORY: dmem_err=1 -> stat=ADR, go to HALT; wb_en is never issued for that instruction.
- Next-PC rule, registered in PCUPD:
  - icode=8 (call) -> valC
  - icode=7 (jXX) -> cnd ? valC : valP
  - icode=9 (ret) -> valM
  - all other icodes -> valP
- icode and cnd are latched internally in DECODE and MEMORY respectively, so later changes on those inputs are ignored.
- On a fault, pc holds the address of the faulting instruction.
- HALT: terminal state. All enables are 0, halted=1, stat is held, run is ignored. Only rst leaves HALT.
- instr_cnt increments in PCUPD. cycle_cnt increments in every state except IDLE and HALT. Both counters wrap modulo 2^CNT_W.
- run deasserted mid-instruction: the current instruction completes through PCUPD, then the FSM goes to IDLE.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: adds input step (1 bit). IDLE -> FETCH requires a step pulse (run is ignored), and PCUPD always returns to IDLE. Result: exactly one instruction per step.
- Not defined: no step port; run-level behaviour as above.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (HALT=0, NOP=1, … POPQ=11)
  - stat encodings (AOK=1, HLT=2, ADR=3, INS=4)
  - the FSM state enum
- Natural sub-module next_pc_sel: combinational selection of the new PC from icode, cnd, valC, valP, valM. It is reused by a future pipelined PC-prediction unit.

Test Plan:
- rst, then run=1 with icode=3 and valP=10 -> fetch_en at cycles 1, 7, 13; pc=10 after the first PCUPD; instr_cnt=1 after 6 cycles.
- jXX with valC=0x40, valP=9: cnd=1 -> pc=0x40; cnd=0 -> pc=9.
- call with valC=0x100 -> pc=0x100; then ret with valM=0x0A -> pc=0x0A.
- instr_valid=0 and icode=0 together in DECODE -> stat=4, halted=1, no execute_en; run toggling afterwards leaves pc unchanged.
- pc=1015 -> stat=3 in FETCH. dmem_err=1 in MEMORY -> stat=3 and wb_en never asserted. rst in WB of a following run -> pc=0, stat=1, counters 0.
- With SEQ_SINGLE_STEP_EN: three step pulses -> instr_cnt=3, FSM in IDLE between pulses.
